// File: rtl/smart_home_cfg_arbiter.sv
// Round-robin arbiter granting three requesters access to the SmartHomeSystem configuration port.
// Optional lockout after repeated password failures is built when CFG_LOCKOUT_EN is defined.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | no owner; arbitrate among pending requests
// S_CHECK   | winner granted; latched password compared against PASSWORD
// S_ACTIVE  | request raised towards SmartHomeSystem with password
// S_CONFIRM | confirm and confdata held for HOLD cycles
// S_RELEASE | request/confirm dropped, done pulse to the owner
module smart_home_cfg_arbiter #(
  parameter logic [1:0] PASSWORD    = 2'b00,
  parameter int         HOLD        = 2,
  parameter int         LOCK_CYCLES = 16
) (
  input  logic         clk,
  input  logic         arst,
  input  logic [2:0]   req,
  input  logic [5:0]   req_pwd,
  input  logic [104:0] req_data,
  output logic [2:0]   grant,
  output logic [2:0]   done,
  output logic [2:0]   nak,
  output logic         request,
  output logic         confirm,
  output logic [1:0]   password,
  output logic [34:0]  confdata,
  output logic         busy,
  output logic         locked
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ACTIVE, S_CONFIRM, S_RELEASE} state_t;

  state_t      state;
  logic [1:0]  ptr;
  logic [1:0]  win;
  logic [1:0]  pwd_q;
  logic [34:0] data_q;
  logic [3:0]  hold_cnt;
  logic [1:0]  pick;
  logic        pwd_match;

  // First requester at or after ptr, wrapping 2 -> 0.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic [1:0] sel;
    logic       found;
    idx   = p;
    sel   = p;
    found = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (!found && r[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end
    return sel;
  endfunction

  function automatic logic [1:0] next_idx(input logic [1:0] w);
    return (w == 2'd2) ? 2'd0 : w + 2'd1;
  endfunction

  assign pick      = rr_pick(req, ptr);
  assign pwd_match = (pwd_q == PASSWORD);

  always_ff @(posedge clk) begin
    if (arst) begin
      state    <= S_IDLE;
      ptr      <= 2'd0;
      win      <= 2'd0;
      pwd_q    <= 2'd0;
      data_q   <= '0;
      hold_cnt <= 4'd0;
      grant    <= 3'b000;
      done     <= 3'b000;
      nak      <= 3'b000;
      request  <= 1'b0;
      confirm  <= 1'b0;
      password <= 2'd0;
      confdata <= '0;
      busy     <= 1'b0;
    end else begin
      done <= 3'b000;
      nak  <= 3'b000;
      case (state)
        S_IDLE: begin
          grant    <= 3'b000;
          request  <= 1'b0;
          confirm  <= 1'b0;
          password <= 2'd0;
          confdata <= '0;
          busy     <= 1'b0;
          if (|req) begin
            win    <= pick;
            pwd_q  <= req_pwd[2*pick +: 2];
            data_q <= req_data[35*pick +: 35];
            grant  <= 3'b001 << pick;
            busy   <= 1'b1;
            state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (pwd_match && !locked) begin
            request  <= 1'b1;
            password <= pwd_q;
            state    <= S_ACTIVE;
          end else begin
            grant <= 3'b000;
            busy  <= 1'b0;
            nak   <= 3'b001 << win;
            ptr   <= next_idx(win);
            state <= S_IDLE;
          end
        end
        S_ACTIVE: begin
          confirm  <= 1'b1;
          confdata <= data_q;
          hold_cnt <= 4'(HOLD - 1);
          state    <= S_CONFIRM;
        end
        S_CONFIRM: begin
          if (hold_cnt == 4'd0) begin
            request  <= 1'b0;
            confirm  <= 1'b0;
            password <= 2'd0;
            confdata <= '0;
            done     <= 3'b001 << win;
            ptr      <= next_idx(win);
            state    <= S_RELEASE;
          end else begin
            hold_cnt <= hold_cnt - 4'd1;
          end
        end
        S_RELEASE: begin
          grant <= 3'b000;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CFG_LOCKOUT_EN
  localparam int LW = $clog2(LOCK_CYCLES + 1);

  logic [1:0]    fail_cnt;
  logic [LW-1:0] lock_tmr;

  // Rejections while already locked are not counted; expiry clears the history.
  always_ff @(posedge clk) begin
    if (arst) begin
      fail_cnt <= 2'd0;
      lock_tmr <= '0;
      locked   <= 1'b0;
    end else if (locked) begin
      if (lock_tmr == '0) begin
        locked   <= 1'b0;
        fail_cnt <= 2'd0;
      end else begin
        lock_tmr <= lock_tmr - LW'(1);
      end
    end else if (state == S_CHECK) begin
      if (pwd_match) begin
        fail_cnt <= 2'd0;
      end else if (fail_cnt == 2'd2) begin
        locked   <= 1'b1;
        lock_tmr <= LW'(LOCK_CYCLES - 1);
      end else begin
        fail_cnt <= fail_cnt + 2'd1;
      end
    end
  end
`else
  assign locked = 1'b0;
`endif

endmodule

// File: doc/smart_home_cfg_arbiter.md
SMART_HOME_CFG_ARBITER -- requirements
Module: smart_home_cfg_arbiter

Interface
REQ-001 Parameters (name, default, meaning):
  PASSWORD, 2'b00, password accepted for configuration access.
  HOLD, 2, cycles confirm/confdata held (1..15).
  LOCK_CYCLES, 16, lockout duration in cycles (CFG_LOCKOUT_EN only).
REQ-002 Ports (name, direction, width, meaning):
  clk       input   1    rising-edge clock
  arst      input   1    reset, synchronous, active-high
  req       input   3    per-requester configuration request, held until done/nak
  req_pwd   input   6    requester i password at [2i+1:2i]
  req_data  input   105  requester i confdata at [35i+34:35i]
  grant     output  3    one-hot owner of the configuration port
  done      output  3    one-cycle pulse, transaction completed
  nak       output  3    one-cycle pulse, transaction rejected
  request   output  1    to SmartHomeSystem request
  confirm   output  1    to SmartHomeSystem confirm
  password  output  2    to SmartHomeSystem password
  confdata  output  35   to SmartHomeSystem confdata
  busy      output  1    state != IDLE
  locked    output  1    lockout active

Function
REQ-003 All outputs are registered; FSM states IDLE, CHECK, ACTIVE, CONFIRM, RELEASE.
REQ-004 IDLE: all outputs 0; if any req bit is 1, select winner w by round-robin starting at index ptr, latch req_pwd/req_data slices of w, go to CHECK.
REQ-005 ptr resets to 0; after any done or nak, ptr = (w+1) mod 3.
REQ-006 CHECK (1 cycle): grant[w]=1; latched pwd == PASSWORD (and not locked) -> ACTIVE; else -> IDLE with nak[w]=1 for that one cycle and grant cleared.
REQ-007 ACTIVE (1 cycle): request=1, confirm=0, password=latched pwd.
REQ-008 CONFIRM (HOLD cycles, counted by 4-bit counter): request=1, confirm=1, password and confdata=latched values.
REQ-009 RELEASE (1 cycle): request=0, confirm=0, confdata=0, done[w]=1; then IDLE with grant=0.
REQ-010 grant[w] stays 1 from CHECK through RELEASE; grant is never multi-hot.
REQ-011 Latency: req sampled at edge 0 -> CHECK after edge 1, ACTIVE after edge 2, CONFIRM edges 3..2+HOLD, done after edge 3+HOLD (edge 5 for HOLD=2).
REQ-012 Inputs req/req_pwd/req_data are ignored after latching; deassertion of req[w] mid-transaction does not abort it.
REQ-013 Simultaneous requests: exactly one served; others wait; a requester still asserting req after its done/nak has lowest priority next arbitration.
REQ-014 Back-to-back: a new arbitration occurs in the IDLE cycle following RELEASE or nak (minimum one idle cycle between transactions).

Reset
REQ-015 arst=1 at a clk rising edge forces state IDLE, ptr=0, all counters 0 and every output to 0 on that edge.
REQ-016 Reset mid-transaction aborts it with no done or nak pulse; request/confirm go 0 the same edge.

Configuration
REQ-017 Macro CFG_LOCKOUT_EN defined: a 2-bit counter counts consecutive CHECK rejections (reset by any accepted password); on the third, locked=1 for LOCK_CYCLES cycles, during which every CHECK results in nak; on expiry locked=0 and counter=0.
REQ-018 Macro CFG_LOCKOUT_EN undefined: no counter or timer is built; locked is tied 0; only password mismatch causes nak.

Verification
REQ-019 req=3'b001, req_pwd=0, req_data[34:0]=35'h6AD1CAB2A, HOLD=2 -> grant=001 after edge 1, request=1 edge 2, confirm=1 edges 3-4 with confdata=35'h6AD1CAB2A, done=001 after edge 5.
REQ-020 req=3'b111 held, all correct passwords -> served in order 0,1,2,0 with exactly one grant bit at a time.
REQ-021 req=3'b010, req_pwd[3:2]=2'b11 -> nak=010 one cycle after CHECK, request/confirm never asserted, ptr advances to 2.
REQ-022 arst=1 during CONFIRM -> all outputs 0 next edge, no done; following request completes normally starting from ptr=0.
REQ-023 CFG_LOCKOUT_EN defined: three wrong passwords -> locked=1; correct password during lockout -> nak; after 16 cycles locked=0 and correct password -> done.
